// File: rtl/rect_flip_scheduler_pkg.sv
// Shared types for the rectangle flip scheduler: FSM states and the queued command record.
package rect_flip_pkg;

  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] base_addr;
    logic [1:0]            r1;
    logic [1:0]            r2;
    logic [1:0]            c1;
    logic [1:0]            c2;
  } flip_cmd_t;

  // Orders both corner pairs so the low index always comes first.
  function automatic flip_cmd_t normalize_cmd(flip_cmd_t c);
    flip_cmd_t n;
    n = c;
    if (c.r1 > c.r2) begin
      n.r1 = c.r2;
      n.r2 = c.r1;
    end
    if (c.c1 > c.c2) begin
      n.c1 = c.c2;
      n.c2 = c.c1;
    end
    return n;
  endfunction

endpackage

// File: rtl/rect_flip_scheduler_if.sv
// Command intake and flip-controller handshake bundled for the scheduler.
interface rect_flip_scheduler_if
  import rect_flip_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base_addr;
  logic [1:0]        cmd_r1;
  logic [1:0]        cmd_r2;
  logic [1:0]        cmd_c1;
  logic [1:0]        cmd_c2;

  logic              flip_start;
  logic [ADDR_W-1:0] flip_base_addr;
  logic [1:0]        flip_r1;
  logic [1:0]        flip_r2;
  logic [1:0]        flip_c1;
  logic [1:0]        flip_c2;
  logic              flip_done;

  modport slave (
    input  cmd_valid, cmd_base_addr, cmd_r1, cmd_r2, cmd_c1, cmd_c2, flip_done,
    output cmd_ready, flip_start, flip_base_addr, flip_r1, flip_r2, flip_c1, flip_c2
  );

  modport master (
    output cmd_valid, cmd_base_addr, cmd_r1, cmd_r2, cmd_c1, cmd_c2, flip_done,
    input  cmd_ready, flip_start, flip_base_addr, flip_r1, flip_r2, flip_c1, flip_c2
  );

endinterface

// File: rtl/rect_flip_scheduler_fifo.sv
// Small first-in first-out command queue; pushes while full are discarded.
module flip_cmd_fifo
  import rect_flip_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push_i,
  input  flip_cmd_t din_i,
  input  logic      pop_i,
  output flip_cmd_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flip_cmd_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic [PW:0]     count_d;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Occupancy moves by one per accepted push or pop, unchanged when both happen.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because the depth is a power of two; reset flushes the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/rect_flip_scheduler.sv
// Queues rectangle-flip commands and issues them one at a time to the flip controller.
module rect_flip_scheduler
  import rect_flip_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rect_flip_scheduler_if.slave bus,
  input  logic                 clear_err,
  output logic                 busy,
  output logic [7:0]           done_count,
  output logic                 timeout_err
);

  localparam int             CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [7:0]        done_count_q;
  logic              timeout_err_q;
  logic              start_q;
  logic [ADDR_W-1:0] flip_base_addr_q;
  logic [1:0]        flip_r1_q, flip_r2_q, flip_c1_q, flip_c2_q;

  flip_cmd_t raw_cmd;
  flip_cmd_t push_cmd;
  flip_cmd_t head_cmd;
  logic      q_full;
  logic      q_empty;
  logic      hit_done;
  logic      hit_timeout;

  assign raw_cmd  = '{base_addr: bus.cmd_base_addr, r1: bus.cmd_r1, r2: bus.cmd_r2,
                      c1: bus.cmd_c1, c2: bus.cmd_c2};
  assign push_cmd = normalize_cmd(raw_cmd);

  flip_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (bus.cmd_valid),
    .din_i   (push_cmd),
    .pop_i   (state_q == ISSUE),
    .dout_o  (head_cmd),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // A done pulse wins over an expiring wait counter in the same cycle.
  assign hit_done    = (state_q == WAIT) && bus.flip_done;
  assign hit_timeout = (state_q == WAIT) && !bus.flip_done && (wait_cnt_q == LAST);

  // Sequencing: idle until work arrives, issue, wait for completion, one idle gap cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!q_empty) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (hit_done || hit_timeout) state_d = GAP;
      GAP:     state_d = q_empty ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
    wait_cnt_d = ((state_q == WAIT) && (state_d == WAIT)) ? wait_cnt_q + 1'b1 : '0;
  end

  // All state and outputs register here; the issued fields hold until the next issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      wait_cnt_q       <= '0;
      done_count_q     <= '0;
      timeout_err_q    <= 1'b0;
      start_q          <= 1'b0;
      flip_base_addr_q <= '0;
      flip_r1_q        <= '0;
      flip_r2_q        <= '0;
      flip_c1_q        <= '0;
      flip_c2_q        <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      start_q    <= (state_q == ISSUE);
      if (hit_done) done_count_q <= done_count_q + 8'd1;
      if (hit_timeout)    timeout_err_q <= 1'b1;
      else if (clear_err) timeout_err_q <= 1'b0;
      if (state_q == ISSUE) begin
        flip_base_addr_q <= head_cmd.base_addr;
        flip_r1_q        <= head_cmd.r1;
        flip_r2_q        <= head_cmd.r2;
        flip_c1_q        <= head_cmd.c1;
        flip_c2_q        <= head_cmd.c2;
      end
    end
  end

  assign bus.cmd_ready      = !q_full;
  assign bus.flip_start     = start_q;
  assign bus.flip_base_addr = flip_base_addr_q;
  assign bus.flip_r1        = flip_r1_q;
  assign bus.flip_r2        = flip_r2_q;
  assign bus.flip_c1        = flip_c1_q;
  assign bus.flip_c2        = flip_c2_q;
  assign busy               = !q_empty || (state_q == ISSUE) || (state_q == WAIT);
  assign done_count         = done_count_q;
  assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_rect_flip_scheduler.sv
// Testbench for rect_flip_scheduler: directed scenarios plus random traffic against a command-level model.
module tb_rect_flip_scheduler;

  localparam int TIMEOUT    = 16;
  localparam int FIFO_DEPTH = 4;

  logic       clk;
  logic       reset_n;
  logic       clear_err;
  logic       busy;
  logic [7:0] done_count;
  logic       timeout_err;

  rect_flip_scheduler_if #(.ADDR_W(8)) bus ();

  rect_flip_scheduler #(
    .ADDR_W     (8),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .clear_err   (clear_err),
    .busy        (busy),
    .done_count  (done_count),
    .timeout_err (timeout_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;
  int startsSeen = 0;
  bit sawWrap = 0;
  logic [7:0] prevCount = 8'd0;

  // Command-level reference: pending commands, whether one is about to launch or is in flight.
  logic [15:0] mq[$];
  bit          launchPending;
  bit          opActive;
  int          waited;
  bit          expStart;
  logic [15:0] expFields;
  int          expCount;
  bit          expErr;

  function automatic logic [15:0] norm(logic [7:0] a, logic [1:0] r1, logic [1:0] r2,
                                       logic [1:0] c1, logic [1:0] c2);
    logic [1:0] rl, rh, cl, ch;
    rl = (r1 < r2) ? r1 : r2;
    rh = (r1 < r2) ? r2 : r1;
    cl = (c1 < c2) ? c1 : c2;
    ch = (c1 < c2) ? c2 : c1;
    return {a, rl, rh, cl, ch};
  endfunction

  task automatic modelReset();
    mq.delete();
    launchPending = 0;
    opActive      = 0;
    waited        = 0;
    expStart      = 0;
    expFields     = '0;
    expCount      = 0;
    expErr        = 0;
  endtask

  task automatic modelEdge();
    bit hadEntries, hasRoom, timedOut;
    hadEntries = (mq.size() != 0);
    hasRoom    = (mq.size() < FIFO_DEPTH);
    timedOut   = 0;
    expStart   = 0;
    if (launchPending) begin
      expFields     = mq.pop_front();
      expStart      = 1;
      launchPending = 0;
      opActive      = 1;
      waited        = 0;
    end else if (opActive) begin
      waited++;
      if (bus.flip_done) begin
        expCount = (expCount + 1) % 256;
        opActive = 0;
      end else if (waited == TIMEOUT) begin
        timedOut = 1;
        opActive = 0;
      end
    end else if (hadEntries) begin
      launchPending = 1;
    end
    if (timedOut)       expErr = 1;
    else if (clear_err) expErr = 0;
    if (bus.cmd_valid && hasRoom)
      mq.push_back(norm(bus.cmd_base_addr, bus.cmd_r1, bus.cmd_r2, bus.cmd_c1, bus.cmd_c2));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("flip_start", 32'(bus.flip_start), 32'(expStart));
    check("flip_fields", 32'({bus.flip_base_addr, bus.flip_r1, bus.flip_r2, bus.flip_c1, bus.flip_c2}),
          32'(expFields));
    check("busy", 32'(busy), 32'(mq.size() != 0 || launchPending || opActive));
    check("done_count", 32'(done_count), 32'(expCount));
    check("timeout_err", 32'(timeout_err), 32'(expErr));
    check("cmd_ready", 32'(bus.cmd_ready), 32'(mq.size() < FIFO_DEPTH));
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] a, input logic [1:0] r1,
                               input logic [1:0] r2, input logic [1:0] c1, input logic [1:0] c2,
                               input bit dn, input bit clr);
    bus.cmd_valid     = v;
    bus.cmd_base_addr = a;
    bus.cmd_r1        = r1;
    bus.cmd_r2        = r2;
    bus.cmd_c1        = c1;
    bus.cmd_c2        = c2;
    bus.flip_done     = dn;
    clear_err         = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) modelEdge();
    else         modelReset();
    #1;
    checkOutput();
    if (bus.flip_start) startsSeen++;
    if (prevCount == 8'd255 && done_count == 8'd0) sawWrap = 1;
    prevCount = done_count;
  endtask

  task automatic idle(input int n);
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pushCmd(input logic [7:0] a, input logic [1:0] r1, input logic [1:0] r2,
                         input logic [1:0] c1, input logic [1:0] c2);
    applyStimulus(1, a, r1, r2, c1, c2, 0, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doneTick();
    bus.flip_done = 1'b1;
    tick();
    bus.flip_done = 1'b0;
  endtask

  task automatic waitStart(input string tag);
    int n;
    n = 0;
    while (!bus.flip_start && n < 12) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.flip_start), 32'd1);
  endtask

  // Hard stop in case something stalls the sequence below.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int cnt0;
    reset_n = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0);
    modelReset();
    #3;
    check("rst_start", 32'(bus.flip_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(done_count), 0);
    check("rst_err", 32'(timeout_err), 0);
    check("rst_ready", 32'(bus.cmd_ready), 1);
    tick();
    tick();
    reset_n = 1'b1;
    idle(2);

    // Single command: start two edges after the push, fields as given.
    pushCmd(8'h10, 1, 2, 0, 3);
    tick();
    check("single_no_early_start", 32'(bus.flip_start), 0);
    tick();
    check("single_start", 32'(bus.flip_start), 1);
    check("single_fields", 32'({bus.flip_base_addr, bus.flip_r1, bus.flip_r2, bus.flip_c1, bus.flip_c2}),
          32'h1063);
    idle(9);
    doneTick();
    tick();
    check("single_count", 32'(done_count), 1);
    check("single_busy_after", 32'(busy), 0);

    // Corner normalization on the push path.
    pushCmd(8'h22, 3, 0, 2, 1);
    waitStart("norm_start");
    check("norm_fields", 32'({bus.flip_base_addr, bus.flip_r1, bus.flip_r2, bus.flip_c1, bus.flip_c2}),
          32'h2236);
    idle(3);
    doneTick();
    idle(2);

    // Full queue behind an in-flight command; fifth push is dropped.
    pushCmd(8'h30, 0, 1, 0, 1);
    waitStart("full_first_start");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'h40 + 8'(i), 2'(i), 0, 1, 2'(i), 0, 0);
      tick();
      if (i == 3) check("full_ready_low", 32'(bus.cmd_ready), 0);
    end
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0);
    doneTick();
    base = startsSeen;
    for (int k = 0; k < 4; k++) begin
      waitStart("full_drain_start");
      check("full_order", 32'(bus.flip_base_addr), 32'(8'h40 + 8'(k)));
      idle(2);
      doneTick();
    end
    idle(6);
    check("full_start_total", 32'(startsSeen - base), 4);

    // Timeout with a second command queued behind it.
    cnt0 = expCount;
    pushCmd(8'h50, 1, 1, 1, 1);
    waitStart("tmo_start");
    pushCmd(8'h51, 2, 1, 2, 1);
    idle(14);
    check("tmo_not_yet", 32'(timeout_err), 0);
    tick();
    check("tmo_set", 32'(timeout_err), 1);
    check("tmo_count_same", 32'(done_count), 32'(cnt0));
    waitStart("tmo_next_start");
    check("tmo_next_addr", 32'(bus.flip_base_addr), 32'h51);
    idle(2);
    doneTick();
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 1);
    tick();
    check("clear_err", 32'(timeout_err), 0);
    idle(2);

    // Done arriving on the final wait cycle counts and sets no error.
    cnt0 = expCount;
    pushCmd(8'h60, 0, 0, 0, 0);
    waitStart("edge_start");
    idle(15);
    doneTick();
    check("edge_done_counted", 32'(done_count), 32'((cnt0 + 1) % 256));
    check("edge_no_err", 32'(timeout_err), 0);
    idle(2);

    // Clear requested in the same cycle as a timeout leaves the error set.
    pushCmd(8'h61, 0, 0, 0, 0);
    waitStart("clr_start");
    idle(15);
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 1);
    tick();
    check("clr_vs_tmo", 32'(timeout_err), 1);
    tick();
    check("clr_after", 32'(timeout_err), 0);
    idle(2);

    // Done pulses while idle are ignored.
    cnt0 = expCount;
    doneTick();
    doneTick();
    check("idle_done_ignored", 32'(done_count), 32'(cnt0));

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom % 2) == 1, 8'($urandom), 2'($urandom), 2'($urandom),
                    2'($urandom), 2'($urandom),
                    opActive ? (($urandom % 4) == 0) : (($urandom % 16) == 0),
                    ($urandom % 20) == 0);
      tick();
    end
    idle(20);

    // Keep the queue fed and complete at once until the counter wraps.
    for (int c = 0; c < 1500 && !sawWrap; c++) begin
      applyStimulus(1, 8'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    opActive, 0);
      tick();
    end
    check("count_wrap", 32'(sawWrap), 1);
    idle(10);

    // Reset in the middle of a wait with two commands queued.
    pushCmd(8'h70, 1, 0, 1, 0);
    waitStart("rst_mid_start");
    pushCmd(8'h71, 0, 0, 0, 0);
    pushCmd(8'h72, 0, 0, 0, 0);
    idle(2);
    reset_n = 1'b0;
    modelReset();
    #1;
    check("mid_rst_start", 32'(bus.flip_start), 0);
    check("mid_rst_fields", 32'({bus.flip_base_addr, bus.flip_r1, bus.flip_r2, bus.flip_c1, bus.flip_c2}), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_count", 32'(done_count), 0);
    check("mid_rst_err", 32'(timeout_err), 0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 1);
    tick();
    reset_n = 1'b1;
    base = startsSeen;
    idle(12);
    check("mid_rst_no_start", 32'(startsSeen - base), 0);
    pushCmd(8'h7A, 2, 3, 0, 1);
    waitStart("post_rst_start");
    check("post_rst_addr", 32'(bus.flip_base_addr), 32'h7A);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
